// File: rtl/comp_serial_nbit.sv
// Bit-serial n-bit magnitude comparator.
// Operands are captured on a valid/ready accept, scanned MSB first one bit per
// clock with early exit on the first differing bit, and the one-hot
// sma/eq/gre result is presented on a second valid/ready handshake.
module comp_serial_nbit #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         sma,
  output logic         eq,
  output logic         gre
);

  // Bit index width; a 1-bit compare still needs a 1-bit index register.
  localparam int IW = (n > 1) ? $clog2(n) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  typedef struct packed {
    logic sma;
    logic eq;
    logic gre;
  } res_t;

  state_t         state, state_nx;
  logic [n-1:0]   a_r, b_r, a_nx, b_nx;
  logic [IW-1:0]  idx, idx_nx;
  res_t           res, res_nx;
  logic           bit_a, bit_b;

  // Current bit pair under inspection, taken from the registered operands.
  assign bit_a = a_r[idx];
  assign bit_b = b_r[idx];

  // Handshake flags decode straight from the state register, so no input
  // reaches an output without passing through a flop.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sma       = res.sma;
  assign eq        = res.eq;
  assign gre       = res.gre;

  // Next-state, operand capture, scan index and result flags.
  always_comb begin
    state_nx = state;
    a_nx     = a_r;
    b_nx     = b_r;
    idx_nx   = idx;
    res_nx   = res;
    case (state)
      IDLE: begin
        if (in_valid) begin
          a_nx     = a;
          b_nx     = b;
          idx_nx   = IW'(n - 1);
          state_nx = SCAN;
        end
      end
      SCAN: begin
        if (bit_a && !bit_b) begin
          res_nx.gre = 1'b1;
          state_nx   = DONE;
        end else if (!bit_a && bit_b) begin
          res_nx.sma = 1'b1;
          state_nx   = DONE;
        end else if (idx == '0) begin
          // All bits matched down to bit 0; idx is never decremented past 0.
          res_nx.eq = 1'b1;
          state_nx  = DONE;
        end else begin
          idx_nx = idx - 1'b1;
        end
      end
      DONE: begin
        // Result holds until the consumer takes it; no accept this cycle.
        if (out_ready) begin
          res_nx   = '0;
          state_nx = IDLE;
        end
      end
      default: begin
        res_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      res   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      res   <= res_nx;
      a_r   <= a_nx;
      b_r   <= b_nx;
      idx   <= idx_nx;
    end
  end

endmodule
